// File: rtl/bridge_cmd_sequencer.sv
// Command sequencer for the UART-to-bus bridge: parses framed read/write
// commands from the RX FIFO, issues one bus transaction, returns one response byte.
module bridge_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_deq,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic                  ddone,
  input  logic [DATA_WIDTH-1:0] drdata,
  output logic [7:0]            u_din,
  output logic                  u_en,
  input  logic                  u_tx_busy,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  timeout
);

  localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int unsigned WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AC_W       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AC_W-1:0] AC_LAST = AC_W'(ADDR_BYTES - 1);

  localparam logic [7:0] HDR_READ  = 8'hAA;
  localparam logic [7:0] HDR_WRITE = 8'hAB;
  localparam logic [7:0] RESP_WACK = 8'hAC;
  localparam logic [7:0] RESP_TO   = 8'hEE;

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_RESP, S_HOLD
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   wd;
  logic [AC_W-1:0]   acnt;
  logic              consume;
  logic              stall;

  assign consume  = (state == S_HDR) || (state == S_ADDR) || (state == S_DATA);
  assign fifo_deq = !rst && consume && !fifo_empty;

  // A stall cycle is one where the watchdog runs because the awaited event is absent;
  // an event in the expiry cycle therefore takes the normal path.
  assign stall = (((state == S_ADDR) || (state == S_DATA)) && fifo_empty) ||
                 ((state == S_ISSUE) && !dready) ||
                 ((state == S_WAIT) && !ddone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HDR;
      wd        <= '0;
      acnt      <= '0;
      daddr     <= '0;
      dwdata    <= '0;
      dmode     <= 1'b0;
      dvalid    <= 1'b0;
      u_din     <= '0;
      u_en      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      u_en      <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      if (stall && (wd == WD_LAST)) begin
        wd      <= '0;
        dvalid  <= 1'b0;
        timeout <= 1'b1;
        u_din   <= RESP_TO;
        state   <= S_RESP;
      end else begin
        wd <= stall ? wd + 1'b1 : '0;
        case (state)
          S_HDR: begin
            if (!fifo_empty) begin
              if ((fifo_dout == HDR_READ) || (fifo_dout == HDR_WRITE)) begin
                dmode <= fifo_dout[0];
                acnt  <= '0;
                busy  <= 1'b1;
                state <= S_ADDR;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          S_ADDR: begin
            if (!fifo_empty) begin
              daddr <= ADDR_WIDTH'({daddr, fifo_dout});
              if (acnt == AC_LAST) begin
                if (dmode) begin
                  state <= S_DATA;
                end else begin
                  dvalid <= 1'b1;
                  state  <= S_ISSUE;
                end
              end else begin
                acnt <= acnt + 1'b1;
              end
            end
          end
          S_DATA: begin
            if (!fifo_empty) begin
              dwdata <= DATA_WIDTH'(fifo_dout);
              dvalid <= 1'b1;
              state  <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (dready) begin
              dvalid <= 1'b0;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ddone) begin
              u_din <= dmode ? RESP_WACK : 8'(drdata);
              state <= S_RESP;
            end
          end
          S_RESP: begin
            if (!u_tx_busy) begin
              u_en  <= 1'b1;
              state <= S_HOLD;
            end
          end
          S_HOLD: begin
            busy  <= 1'b0;
            state <= S_HDR;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_HDR;
          end
        endcase
      end
    end
  end

endmodule
